// File: rtl/types.sv
// Shared types for the instruction/data Avalon-MM arbiter.
package types;

  typedef logic [31:0] word;

  typedef enum logic {
    REQ_INSTR = 1'b0,
    REQ_DATA  = 1'b1
  } req_tag;

endpackage

// File: rtl/read_tag_fifo.sv
// Tag FIFO that records which requester owns each outstanding downstream read.
module read_tag_fifo
  import types::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  req_tag                     push_tag,
  input  logic                       pop,
  output req_tag                     head_tag,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0] wr_ptr;
  logic [PW:0] rd_ptr;
  req_tag      mem [DEPTH];
  logic        do_pop;
  logic        do_push;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign do_pop  = pop && !empty;
  // a full FIFO still takes a push when the head leaves in the same cycle
  assign do_push = push && (!full || do_pop);
  assign count   = wr_ptr - rd_ptr;
  assign head_tag = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PW-1:0]] <= push_tag;
  end

endmodule

// File: rtl/avalon_arbiter.sv
// Round-robin arbiter merging the CPU instruction and data managers onto one
// Avalon-MM host port, with in-order read response routing.
//
//  state  | meaning
//  IDLE   | grant decided combinationally from current requests
//  LOCK_I | instruction command stalled downstream, grant held
//  LOCK_D | data command stalled downstream, grant held
module avalon_arbiter
  import types::*;
#(
  parameter int MAX_PENDING = 4,
  parameter bit DATA_FIRST  = 1'b1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  word                              i_address,
  input  logic [3:0]                       i_byteenable,
  input  logic                             i_read,
  output logic                             i_waitrequest,
  output word                              i_agent_to_host,
  output logic                             i_readdatavalid,
  input  word                              d_address,
  input  logic [3:0]                       d_byteenable,
  input  logic                             d_read,
  input  logic                             d_write,
  input  word                              d_host_to_agent,
  output logic                             d_waitrequest,
  output word                              d_agent_to_host,
  output logic                             d_readdatavalid,
  output word                              m_address,
  output logic [3:0]                       m_byteenable,
  output logic                             m_read,
  output logic                             m_write,
  output word                              m_host_to_agent,
  input  logic                             m_waitrequest,
  input  word                              m_agent_to_host,
  input  logic                             m_readdatavalid,
  output logic [$clog2(MAX_PENDING+1)-1:0] pending_count,
  output logic                             protocol_error
);

  typedef enum logic [1:0] {IDLE, LOCK_I, LOCK_D} state_t;

  state_t state;
  req_tag last_grant;
  req_tag grant_sel;
  logic   grant_valid;
  logic   req_i, req_d;
  logic   sel_read, sel_write;
  logic   read_blocked, stall, accepted;
  logic   fifo_full, fifo_empty, rdv_ok;
  req_tag head_tag;

  assign req_i = i_read;
  assign req_d = d_read || d_write;

  always_comb begin
    grant_valid = 1'b0;
    grant_sel   = REQ_DATA;
    case (state)
      LOCK_I: begin grant_valid = 1'b1; grant_sel = REQ_INSTR; end
      LOCK_D: begin grant_valid = 1'b1; grant_sel = REQ_DATA;  end
      default: begin
        if (req_i && req_d) begin
          grant_valid = 1'b1;
          grant_sel   = (last_grant == REQ_DATA) ? REQ_INSTR : REQ_DATA;
        end else if (req_d) begin
          grant_valid = 1'b1;
          grant_sel   = REQ_DATA;
        end else if (req_i) begin
          grant_valid = 1'b1;
          grant_sel   = REQ_INSTR;
        end
      end
    endcase
    if (rst) grant_valid = 1'b0;
  end

  assign sel_read  = (grant_sel == REQ_DATA) ? d_read : i_read;
  assign sel_write = (grant_sel == REQ_DATA) && d_write;

  // a pop in the same cycle frees a slot, so only a truly full FIFO blocks
  assign read_blocked = grant_valid && sel_read && fifo_full && !m_readdatavalid;

  assign m_read          = grant_valid && sel_read && !read_blocked;
  assign m_write         = grant_valid && sel_write;
  assign m_address       = (grant_sel == REQ_DATA) ? d_address : i_address;
  assign m_byteenable    = (grant_sel == REQ_DATA) ? d_byteenable : i_byteenable;
  assign m_host_to_agent = d_host_to_agent;

  assign accepted = (m_read || m_write) && !m_waitrequest;
  assign stall    = m_waitrequest || read_blocked;

  assign i_waitrequest = !(grant_valid && grant_sel == REQ_INSTR) || stall;
  assign d_waitrequest = !(grant_valid && grant_sel == REQ_DATA)  || stall;

  assign rdv_ok          = m_readdatavalid && !fifo_empty && !rst;
  assign i_readdatavalid = rdv_ok && (head_tag == REQ_INSTR);
  assign d_readdatavalid = rdv_ok && (head_tag == REQ_DATA);
  assign i_agent_to_host = m_agent_to_host;
  assign d_agent_to_host = m_agent_to_host;

  read_tag_fifo #(.DEPTH(MAX_PENDING)) u_tag_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (accepted && m_read),
    .push_tag (grant_sel),
    .pop      (m_readdatavalid),
    .head_tag (head_tag),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (pending_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      last_grant     <= DATA_FIRST ? REQ_INSTR : REQ_DATA;
      protocol_error <= 1'b0;
    end else begin
      if (accepted) last_grant <= grant_sel;
      if (m_readdatavalid && fifo_empty) protocol_error <= 1'b1;
      case (state)
        IDLE: begin
          if ((m_read || m_write) && m_waitrequest)
            state <= (grant_sel == REQ_DATA) ? LOCK_D : LOCK_I;
        end
        default: begin
          // requester withdrawing its command also releases the lock
          if (accepted || !(sel_read || sel_write)) state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_avalon_arbiter.sv
// Scoreboard bench for avalon_arbiter: drives both managers and models the
// downstream agent, checking grants, forwarding and in-order response routing.
module tb_avalon_arbiter;
  import types::*;

  logic       clk = 1'b0;
  logic       rst;
  word        i_address, d_address, d_host_to_agent, m_agent_to_host;
  logic [3:0] i_byteenable, d_byteenable;
  logic       i_read, d_read, d_write, m_waitrequest, m_readdatavalid;
  logic       i_waitrequest, i_readdatavalid, d_waitrequest, d_readdatavalid;
  word        i_agent_to_host, d_agent_to_host, m_address, m_host_to_agent;
  logic [3:0] m_byteenable;
  logic       m_read, m_write, protocol_error;
  logic [2:0] pending_count;

  typedef struct {
    req_tag tag;
    word    data;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  avalon_arbiter #(.MAX_PENDING(4), .DATA_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst),
    .i_address(i_address), .i_byteenable(i_byteenable), .i_read(i_read),
    .i_waitrequest(i_waitrequest), .i_agent_to_host(i_agent_to_host),
    .i_readdatavalid(i_readdatavalid),
    .d_address(d_address), .d_byteenable(d_byteenable), .d_read(d_read),
    .d_write(d_write), .d_host_to_agent(d_host_to_agent),
    .d_waitrequest(d_waitrequest), .d_agent_to_host(d_agent_to_host),
    .d_readdatavalid(d_readdatavalid),
    .m_address(m_address), .m_byteenable(m_byteenable), .m_read(m_read),
    .m_write(m_write), .m_host_to_agent(m_host_to_agent),
    .m_waitrequest(m_waitrequest), .m_agent_to_host(m_agent_to_host),
    .m_readdatavalid(m_readdatavalid),
    .pending_count(pending_count), .protocol_error(protocol_error)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_read = 0; i_address = '0; i_byteenable = 4'hF;
    d_read = 0; d_write = 0; d_address = '0; d_byteenable = 4'hF; d_host_to_agent = '0;
    m_waitrequest = 0; m_readdatavalid = 0; m_agent_to_host = '0;
  endtask

  task automatic issue_read(input req_tag t, input word addr, input word rdata);
    idle_inputs();
    if (t == REQ_INSTR) begin i_read = 1; i_address = addr; end
    else begin d_read = 1; d_address = addr; end
    #1;
    check("rd_m_read", m_read, 1);
    check("rd_m_addr", m_address, addr);
    check("rd_wait", (t == REQ_INSTR) ? i_waitrequest : d_waitrequest, 0);
    sb.push_back('{t, rdata});
    step();
    idle_inputs();
  endtask

  // drives one downstream response for the scoreboard head and checks routing
  task automatic respond(input bit advance);
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++; n_err++;
      $display("FAIL sb_underflow: got empty expected entry");
      return;
    end
    e = sb.pop_front();
    m_readdatavalid = 1; m_agent_to_host = e.data;
    #1;
    check("rsp_i_valid", i_readdatavalid, e.tag == REQ_INSTR);
    check("rsp_d_valid", d_readdatavalid, e.tag == REQ_DATA);
    check("rsp_data", (e.tag == REQ_INSTR) ? i_agent_to_host : d_agent_to_host, e.data);
    if (advance) begin
      step();
      m_readdatavalid = 0;
    end
  endtask

  initial begin
    idle_inputs();
    rst = 1; i_read = 1; d_write = 1;
    #2;
    check("rst_m_read", m_read, 0);
    check("rst_m_write", m_write, 0);
    check("rst_i_wait", i_waitrequest, 1);
    check("rst_d_wait", d_waitrequest, 1);
    check("rst_pending", pending_count, 0);
    check("rst_perr", protocol_error, 0);
    step(); step();
    idle_inputs();
    rst = 0;
    step();

    // first tie after reset goes to data, then instruction
    i_read = 1; i_address = 32'h100; d_read = 1; d_address = 32'h200;
    #1;
    check("tie0_addr", m_address, 32'h200);
    check("tie0_d_wait", d_waitrequest, 0);
    check("tie0_i_wait", i_waitrequest, 1);
    sb.push_back('{REQ_DATA, 32'h11});
    step();
    d_read = 0;
    #1;
    check("tie1_addr", m_address, 32'h100);
    check("tie1_i_wait", i_waitrequest, 0);
    sb.push_back('{REQ_INSTR, 32'h22});
    step();
    idle_inputs();
    check("tie_pending", pending_count, 2);
    respond(1);
    respond(1);
    check("tie_drained", pending_count, 0);

    // stalled data write keeps its lock while instruction waits
    d_write = 1; d_address = 32'h1000; d_host_to_agent = 32'hDEAD_BEEF;
    i_read = 1; i_address = 32'h2000; m_waitrequest = 1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("lock_addr", m_address, 32'h1000);
      check("lock_write", m_write, 1);
      check("lock_i_wait", i_waitrequest, 1);
      step();
    end
    m_waitrequest = 0;
    #1;
    check("lock_acc_addr", m_address, 32'h1000);
    check("lock_acc_wdata", m_host_to_agent, 32'hDEAD_BEEF);
    check("lock_acc_d_wait", d_waitrequest, 0);
    step();
    d_write = 0;
    #1;
    check("after_lock_addr", m_address, 32'h2000);
    check("after_lock_i_wait", i_waitrequest, 0);
    sb.push_back('{REQ_INSTR, 32'h33});
    step();
    idle_inputs();
    respond(1);

    // fill the tag FIFO, write still passes, fifth read blocked until a pop
    for (int k = 0; k < 4; k++) issue_read(REQ_INSTR, 32'h3000 + 4 * k, 32'h40 + k);
    check("full_pending", pending_count, 4);
    d_write = 1; d_address = 32'h4000;
    #1;
    check("full_write", m_write, 1);
    check("full_write_wait", d_waitrequest, 0);
    step();
    idle_inputs();
    i_read = 1; i_address = 32'h5000;
    #1;
    check("blocked_m_read", m_read, 0);
    check("blocked_i_wait", i_waitrequest, 1);
    respond(0);
    check("pushpop_m_read", m_read, 1);
    check("pushpop_i_wait", i_waitrequest, 0);
    sb.push_back('{REQ_INSTR, 32'h55});
    step();
    idle_inputs();
    check("pushpop_pending", pending_count, 4);
    for (int k = 0; k < 4; k++) respond(1);
    check("full_drained", pending_count, 0);

    // interleaved reads return in issue order
    issue_read(REQ_INSTR, 32'h6000, 32'hA);
    issue_read(REQ_DATA, 32'h7000, 32'hB);
    issue_read(REQ_INSTR, 32'h6004, 32'hC);
    respond(1);
    respond(1);
    respond(1);

    // stray response
    m_readdatavalid = 1;
    #1;
    check("stray_i_valid", i_readdatavalid, 0);
    check("stray_d_valid", d_readdatavalid, 0);
    step();
    m_readdatavalid = 0;
    check("stray_perr", protocol_error, 1);
    step(); step();
    check("stray_perr_sticky", protocol_error, 1);

    // asynchronous reset with reads outstanding
    issue_read(REQ_INSTR, 32'h8000, 32'h1);
    issue_read(REQ_DATA, 32'h9000, 32'h2);
    check("pre_rst_pending", pending_count, 2);
    i_read = 1; d_write = 1;
    #2;
    rst = 1;
    #1;
    check("arst_pending", pending_count, 0);
    check("arst_perr", protocol_error, 0);
    check("arst_m_read", m_read, 0);
    check("arst_m_write", m_write, 0);
    check("arst_i_wait", i_waitrequest, 1);
    check("arst_d_wait", d_waitrequest, 1);
    sb.delete();
    step();
    idle_inputs();
    rst = 0;
    step();
    m_readdatavalid = 1;
    #1;
    check("late_i_valid", i_readdatavalid, 0);
    check("late_d_valid", d_readdatavalid, 0);
    step();
    m_readdatavalid = 0;
    check("late_perr", protocol_error, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
